// File: rtl/instruct_cache.sv
// Direct-mapped instruction cache: 8 lines x 16 bytes, zero-stall hits,
// whole-block fill from instruction memory on a miss.
module instruct_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t         state_r;
  logic [7:0]     valid_r;
  logic [2:0]     tag_r [8];
  logic [127:0]   data_r [8];
  logic [2:0]     lat_tag_r;
  logic [2:0]     lat_index_r;
  logic [127:0]   fill_data_r;
  logic           min_wait_r;
  logic           mem_read_r;
  logic [5:0]     mem_address_r;

  logic [2:0]     tag_s;
  logic [2:0]     index_s;
  logic [1:0]     word_s;
  logic           hit_s;
  logic           busywait_s;
  logic           unused_s;

  assign tag_s    = address[9:7];
  assign index_s  = address[6:4];
  assign word_s   = address[3:2];
  assign unused_s = &{1'b0, address[1:0]};

  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign instruction = data_r[index_s][{word_s, 5'd0} +: 32];
  assign mem_read    = mem_read_r;
  assign mem_address = mem_address_r;
  assign busywait    = busywait_s;

  // Stall request: only an IDLE miss depends on the CPU, a fill in flight always stalls
  always_comb begin
    busywait_s = 1'b1;
    case (state_r)
      IDLE:     busywait_s = read && !hit_s;
      MEM_READ: busywait_s = 1'b1;
      UPDATE:   busywait_s = 1'b1;
      default:  busywait_s = 1'b1;
    endcase
  end

  // Miss-handling FSM together with the line storage it fills
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      valid_r       <= 8'd0;
      lat_tag_r     <= 3'd0;
      lat_index_r   <= 3'd0;
      fill_data_r   <= 128'd0;
      min_wait_r    <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_address_r <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        tag_r[i]  <= 3'd0;
        data_r[i] <= 128'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (read && !hit_s) begin
            lat_tag_r     <= tag_s;
            lat_index_r   <= index_s;
            mem_address_r <= {tag_s, index_s};
            mem_read_r    <= 1'b1;
            min_wait_r    <= 1'b0;
            state_r       <= MEM_READ;
          end
        end
        MEM_READ: begin
          // Memory may not have raised its busy flag yet on the first edge
          if (min_wait_r && !mem_busywait) begin
            fill_data_r <= mem_readdata;
            mem_read_r  <= 1'b0;
            state_r     <= UPDATE;
          end else begin
            min_wait_r <= 1'b1;
          end
        end
        UPDATE: begin
          data_r[lat_index_r]  <= fill_data_r;
          tag_r[lat_index_r]   <= lat_tag_r;
          valid_r[lat_index_r] <= 1'b1;
          state_r              <= IDLE;
        end
        default: begin
          mem_read_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
